prog_loader: RTL and testbench
==============================

Name: prog_loader

Overview:
Fills the 16x128 program RAM through its write port 0 from a valid/ready word stream, then releases the processor. Holds proc in reset while loading. After the load completes it raises start and hands RAM port 0 addressing back to the processor's pc. Sits directly upstream of proc and between proc and the program RAM port 0.

Parameters:
DATA_W, 16, program word width
ADDR_W, 7, program RAM address width
DEPTH, 128, program RAM depth in words (must equal 2**ADDR_W)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
load_req  input  1  one-cycle request to start a load; sampled only in IDLE, RUN, ERR
word_count  input  ADDR_W+1  number of words to load; sampled with load_req; legal range 1..DEPTH
in_valid  input  1  stream word valid
in_data  input  DATA_W  stream word
in_ready  output  1  loader accepts in_data this cycle
pc_in  input  ADDR_W  processor program address
prog_read_en_in  input  1  processor program read enable
ram_addr0  output  ADDR_W  program RAM port 0 address
ram_din0  output  DATA_W  program RAM port 0 write data
ram_write_en0  output  1  program RAM port 0 write enable
ram_read_en0  output  1  program RAM port 0 read enable
proc_hold  output  1  high = processor held in reset (drives proc rst_n inverted)
proc_start  output  1  start level to proc
busy  output  1  high in LOAD and FLUSH
done  output  1  one-cycle pulse on entry to RUN
err  output  1  illegal word_count; sticky until next legal load_req or reset

Behaviour:
- Reset values: state IDLE, in_ready 0, ram_write_en0 0, ram_din0 0, write address 0, ram_addr0 0, ram_read_en0 0, proc_hold 1, proc_start 0, busy 0, done 0, err 0.
- States: IDLE, LOAD, FLUSH, RUN, ERR.
- IDLE/RUN/ERR + load_req:
  - word_count in 1..DEPTH -> LOAD. Latch count, clear write address, clear err, proc_hold 1, proc_start 0.
  - word_count 0 or >DEPTH -> ERR, err 1, proc_hold 1, proc_start 0.
- LOAD:
  - in_ready = 1.
  - Handshake = in_valid & in_ready.
  - Each handshake registers ram_write_en0=1, ram_din0=in_data and the current write address. The write reaches the RAM pins one cycle after the handshake.
  - Write address increments after each handshake.
  - Cycles without a handshake drive ram_write_en0=0 on the following cycle.
  - On the handshake of word count-1 -> FLUSH. in_ready is 0 from the next cycle.
- FLUSH: exactly one cycle. The final registered write is presented. Then -> RUN.
- RUN:
  - proc_hold 0, proc_start 1 (level, held).
  - done is 1 in the first RUN cycle only.
  - ram_addr0 = pc_in and ram_read_en0 = prog_read_en_in, combinational (zero added latency to proc fetch).
- All states other than RUN: ram_addr0 = registered write address and ram_read_en0 = 0.
- load_req in LOAD or FLUSH: ignored.
- Address never wraps. Count DEPTH writes addresses 0..DEPTH-1 and the counter is never used beyond that.
- Reset mid-load:
  - Next cycle all outputs take reset values.
  - RAM words already written are not cleared.
  - The partial load is abandoned; a new load_req is required.
- Simultaneous reset and load_req: reset wins.
- in_data is never sampled while in_ready is 0.

Decomposition:
- Shared header/package holds:
  - state encodings (IDLE=0, LOAD=1, FLUSH=2, RUN=3, ERR=4, 3-bit)
  - DATA_W, ADDR_W and DEPTH defaults, for reuse by proc, the program RAM and the bench
- One natural sub-module: prog_port0_mux, the combinational port-0 address/read-enable arbiter between loader and pc. The FSM, counter and write registers stay in prog_loader.

Test Plan:
- Three-word load: load_req at cycle N, word_count=3, in_valid held high with 0x1234, 0xABCD, 0x0001.
  - in_ready 1 in N+1..N+3.
  - Writes addr 0/1/2 in N+2..N+4; FLUSH at N+4.
  - RUN at N+5 with done=1, proc_hold=0, proc_start=1.
  - RAM holds those values.
- Backpressure: word_count=4, in_valid alternating 1/0 -> writes only the cycle after each handshake, addresses 0..3 contiguous, busy high throughout, done once.
- Illegal count: word_count=0, then a separate test with word_count=129.
  - err=1, in_ready stays 0, proc_hold stays 1.
  - Follow with word_count=2 -> err clears next cycle and the load completes.
- Full depth: word_count=128 -> last write addr 127 with data as sent, FLUSH then RUN, no write to addr 0 after the first.
- Reset mid-load: reset pulsed after 5 handshakes of a 10-word load.
  - Next cycle: in_ready 0, ram_write_en0 0, proc_hold 1, busy 0.
  - Addresses 0..4 retain their data.
- RUN handoff: in RUN, pc_in=10, prog_read_en_in=1 -> same cycle ram_addr0=10, ram_read_en0=1. Then load_req count=1 -> next cycle proc_hold=1, proc_start=0, ram_read_en0=0.

Source files
------------

// File: rtl/prog_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : prog_loader_pkg
// Description : Shared sizes and loader state encoding for the program
//               loader, the processor, the program RAM and their benches.
// Revision    : 1.0 - initial release
// ============================================================================
package prog_loader_pkg;

    localparam int DATA_W = 16;   // program word width
    localparam int ADDR_W = 7;    // program RAM address width
    localparam int DEPTH  = 128;  // program RAM depth, equals 2**ADDR_W

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_FLUSH = 3'd2,
        ST_RUN   = 3'd3,
        ST_ERR   = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/prog_port0_mux.sv
`default_nettype none
// ============================================================================
// Module      : prog_port0_mux
// Description : Program RAM port 0 address/read-enable arbiter. The loader
//               owns the port until RUN, then the processor pc drives it
//               with no added latency.
// Revision    : 1.0 - initial release
// ============================================================================
module prog_port0_mux #(
    parameter int ADDR_W = prog_loader_pkg::ADDR_W
) (
    input  logic              i_run_sel,
    input  logic [ADDR_W-1:0] i_load_addr,
    input  logic [ADDR_W-1:0] i_pc,
    input  logic              i_prog_read_en,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_read_en
);
    import prog_loader_pkg::*;

    // Loader address and no reads by default; processor fetch path in RUN.
    always_comb begin
        o_addr    = i_load_addr;
        o_read_en = 1'b0;
        if (i_run_sel) begin
            o_addr    = i_pc;
            o_read_en = i_prog_read_en;
        end
    end

endmodule
`default_nettype wire

// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
// Module      : prog_loader
// Description : Streams a program image into program RAM port 0 from a
//               valid/ready word source, holding the processor in reset,
//               then releases it and hands port 0 to the processor pc.
// Revision    : 1.0 - initial release
// ============================================================================
module prog_loader #(
    parameter int DATA_W = prog_loader_pkg::DATA_W,
    parameter int ADDR_W = prog_loader_pkg::ADDR_W,
    parameter int DEPTH  = prog_loader_pkg::DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_req,
    input  logic [ADDR_W:0]   word_count,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic              prog_read_en_in,
    output logic [ADDR_W-1:0] ram_addr0,
    output logic [DATA_W-1:0] ram_din0,
    output logic              ram_write_en0,
    output logic              ram_read_en0,
    output logic              proc_hold,
    output logic              proc_start,
    output logic              busy,
    output logic              done,
    output logic              err
);
    import prog_loader_pkg::*;

    localparam logic [ADDR_W:0] c_depth_cnt = DEPTH[ADDR_W:0];

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W:0]   r_count;     // words requested for the current load
    logic [ADDR_W-1:0] r_wptr;      // address the next accepted word goes to
    logic [ADDR_W-1:0] r_waddr;     // address of the write on the RAM pins
    logic [DATA_W-1:0] r_din;
    logic              r_we;
    logic              r_done;

    logic              w_accept_req;
    logic              w_count_ok;
    logic              w_load_start;
    logic              w_handshake;
    logic              w_last;

    assign w_count_ok   = (word_count != '0) && (word_count <= c_depth_cnt);
    assign w_accept_req = (r_state == ST_IDLE) || (r_state == ST_RUN) ||
                          (r_state == ST_ERR);
    assign w_load_start = w_accept_req && load_req && w_count_ok;
    assign w_handshake  = in_valid && in_ready;
    assign w_last       = ({1'b0, r_wptr} == (r_count - 1'b1));

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and state-decoded outputs.
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        busy        = 1'b0;
        proc_hold   = 1'b1;
        proc_start  = 1'b0;
        err         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (load_req) w_state_nxt = w_count_ok ? ST_LOAD : ST_ERR;
            end
            ST_LOAD: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (w_handshake && w_last) w_state_nxt = ST_FLUSH;
            end
            ST_FLUSH: begin
                busy        = 1'b1;
                w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                proc_hold  = 1'b0;
                proc_start = 1'b1;
                if (load_req) w_state_nxt = w_count_ok ? ST_LOAD : ST_ERR;
            end
            ST_ERR: begin
                err = 1'b1;
                if (load_req) w_state_nxt = w_count_ok ? ST_LOAD : ST_ERR;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Write pipeline: each accepted word appears on the RAM pins next cycle.
    // The pointer stops on the final word so it never wraps past DEPTH-1.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
            r_wptr  <= '0;
            r_waddr <= '0;
            r_din   <= '0;
            r_we    <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_we   <= w_handshake;
            r_done <= (r_state == ST_FLUSH);
            if (w_load_start) begin
                r_count <= word_count;
                r_wptr  <= '0;
                r_waddr <= '0;
            end else if (w_handshake) begin
                r_din   <= in_data;
                r_waddr <= r_wptr;
                if (!w_last) r_wptr <= r_wptr + 1'b1;
            end
        end
    end

    assign ram_din0      = r_din;
    assign ram_write_en0 = r_we;
    assign done          = r_done;

    prog_port0_mux #(
        .ADDR_W (ADDR_W)
    ) u_port0_mux (
        .i_run_sel      (r_state == ST_RUN),
        .i_load_addr    (r_waddr),
        .i_pc           (pc_in),
        .i_prog_read_en (prog_read_en_in),
        .o_addr         (ram_addr0),
        .o_read_en      (ram_read_en0)
    );

endmodule
`default_nettype wire

// File: tb/tb_prog_loader.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_prog_loader
// Description : Self-checking bench for prog_loader with a behavioural
//               loader model, a program RAM image and directed loads.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prog_loader;
    import prog_loader_pkg::*;

    localparam int DW = DATA_W;
    localparam int AW = ADDR_W;
    localparam int DP = DEPTH;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          load_req = 1'b0;
    logic [AW:0]   word_count = '0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_ready;
    logic [AW-1:0] pc_in = '0;
    logic          prog_read_en_in = 1'b0;
    logic [AW-1:0] ram_addr0;
    logic [DW-1:0] ram_din0;
    logic          ram_write_en0;
    logic          ram_read_en0;
    logic          proc_hold;
    logic          proc_start;
    logic          busy;
    logic          done;
    logic          err;

    always #5 clk = ~clk;

    prog_loader dut (
        .clk             (clk),
        .reset           (reset),
        .load_req        (load_req),
        .word_count      (word_count),
        .in_valid        (in_valid),
        .in_data         (in_data),
        .in_ready        (in_ready),
        .pc_in           (pc_in),
        .prog_read_en_in (prog_read_en_in),
        .ram_addr0       (ram_addr0),
        .ram_din0        (ram_din0),
        .ram_write_en0   (ram_write_en0),
        .ram_read_en0    (ram_read_en0),
        .proc_hold       (proc_hold),
        .proc_start      (proc_start),
        .busy            (busy),
        .done            (done),
        .err             (err)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc++;

    // ---------------- behavioural model ----------------
    // Words still owed by the stream, a one-cycle drain step, then RUN.
    int            m_left = 0;
    bit            m_flush = 0, m_run = 0, m_err = 0, m_done = 0, m_we = 0;
    int            m_next = 0, m_last_addr = 0;
    logic [DW-1:0] m_din = '0;
    bit            m_ok = 0;

    always @(posedge clk) begin
        if (reset) begin
            m_left = 0; m_flush = 0; m_run = 0; m_err = 0; m_done = 0; m_we = 0;
            m_next = 0; m_last_addr = 0; m_din = '0; m_ok = 1;
        end else begin
            m_done = 0;
            m_we   = 0;
            if (m_left > 0) begin
                if (in_valid) begin
                    m_we = 1; m_din = in_data; m_last_addr = m_next;
                    m_next++; m_left--;
                    if (m_left == 0) m_flush = 1;
                end
            end else if (m_flush) begin
                m_flush = 0; m_run = 1; m_done = 1;
            end else if (load_req) begin
                if (word_count >= 1 && word_count <= DP) begin
                    m_left = int'(word_count); m_next = 0; m_last_addr = 0;
                    m_err = 0; m_run = 0;
                end else begin
                    m_err = 1; m_run = 0;
                end
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (m_ok) begin
            chk("in_ready",   32'(in_ready),      32'(m_left > 0));
            chk("busy",       32'(busy),          32'((m_left > 0) || m_flush));
            chk("proc_hold",  32'(proc_hold),     32'(!m_run));
            chk("proc_start", 32'(proc_start),    32'(m_run));
            chk("done",       32'(done),          32'(m_done));
            chk("err",        32'(err),           32'(m_err));
            chk("we",         32'(ram_write_en0), 32'(m_we));
            chk("din",        32'(ram_din0),      32'(m_din));
            chk("addr",       32'(ram_addr0),     m_run ? 32'(pc_in) : 32'(m_last_addr));
            chk("read_en",    32'(ram_read_en0),  m_run ? 32'(prog_read_en_in) : 32'd0);
        end
    end

    // ---------------- program RAM image and event log ----------------
    logic [DW-1:0] ram [DP];
    logic [DW-1:0] tx  [DP];
    int            wr_cnt, wr0_cnt, done_cnt, first_wr_cyc, done_cyc;
    int            contig_bad, wr_expect, last_wr_addr;
    logic [DW-1:0] last_wr_data;

    task automatic clear_logs();
        wr_cnt = 0; wr0_cnt = 0; done_cnt = 0; first_wr_cyc = -1; done_cyc = -1;
        contig_bad = 0; wr_expect = 0; last_wr_addr = -1; last_wr_data = '0;
    endtask

    always @(negedge clk) begin
        if (ram_write_en0 === 1'b1) begin
            ram[ram_addr0] = ram_din0;
            if (first_wr_cyc < 0) first_wr_cyc = cyc;
            if (int'(ram_addr0) != wr_expect) contig_bad++;
            if (ram_addr0 == '0) wr0_cnt++;
            wr_expect    = int'(ram_addr0) + 1;
            last_wr_addr = int'(ram_addr0);
            last_wr_data = ram_din0;
            wr_cnt++;
        end
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_load(input int wc);
        load_req   = 1'b1;
        word_count = (AW+1)'(wc);
        tick();
        load_req   = 1'b0;
    endtask

    task automatic send(input int n, input bit alt);
        int idx = 0;
        int guard = 0;
        bit ph = 1'b1;
        bit hs;
        while (idx < n && guard < 4000) begin
            in_valid = alt ? ph : 1'b1;
            in_data  = tx[idx];
            @(negedge clk);
            hs = in_valid && in_ready;
            tick();
            if (hs) idx++;
            ph = ~ph;
            guard++;
        end
        in_valid = 1'b0;
        chk("send_words_accepted", 32'(idx), 32'(n));
    endtask

    task automatic wait_done(input int bound);
        int k = 0;
        bit seen = 0;
        while (!seen && k < bound) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1;
            k++;
        end
        chk("done_seen", 32'(seen), 32'd1);
        tick();
    endtask

    int n0;

    initial begin
        // Reset state
        repeat (3) tick();
        @(negedge clk);
        chk("rst_in_ready",  32'(in_ready),      32'd0);
        chk("rst_proc_hold", 32'(proc_hold),     32'd1);
        chk("rst_start",     32'(proc_start),    32'd0);
        chk("rst_busy",      32'(busy),          32'd0);
        chk("rst_err",       32'(err),           32'd0);
        chk("rst_we",        32'(ram_write_en0), 32'd0);
        chk("rst_addr",      32'(ram_addr0),     32'd0);
        tick();
        reset = 1'b0;
        tick();

        // Three-word load with in_valid already high alongside load_req
        tx[0] = 16'h1234; tx[1] = 16'hABCD; tx[2] = 16'h0001;
        clear_logs();
        in_valid = 1'b1; in_data = tx[0];
        n0 = cyc;
        start_load(3);
        send(3, 1'b0);
        wait_done(20);
        chk("t3_first_write_cycle", 32'(first_wr_cyc - n0), 32'd2);
        chk("t3_done_cycle",        32'(done_cyc - n0),     32'd5);
        chk("t3_writes",            32'(wr_cnt),            32'd3);
        chk("t3_ram0",              32'(ram[0]),            32'h1234);
        chk("t3_ram1",              32'(ram[1]),            32'hABCD);
        chk("t3_ram2",              32'(ram[2]),            32'h0001);
        chk("t3_hold",              32'(proc_hold),         32'd0);
        chk("t3_start",             32'(proc_start),        32'd1);

        // Backpressure, plus a load_req during LOAD that must be ignored
        tx[0] = 16'h0A0A; tx[1] = 16'h0B0B; tx[2] = 16'h0C0C; tx[3] = 16'h0D0D;
        clear_logs();
        start_load(4);
        load_req = 1'b1; word_count = (AW+1)'(1); in_valid = 1'b0;
        tick();
        load_req = 1'b0;
        send(4, 1'b1);
        wait_done(20);
        chk("bp_writes",  32'(wr_cnt),       32'd4);
        chk("bp_contig",  32'(contig_bad),   32'd0);
        chk("bp_last",    32'(last_wr_addr), 32'd3);
        chk("bp_done_n",  32'(done_cnt),     32'd1);
        chk("bp_ram3",    32'(ram[3]),       32'h0D0D);

        // Illegal count 0, then a legal recovery load
        start_load(0);
        @(negedge clk);
        chk("ill0_err",   32'(err),       32'd1);
        chk("ill0_ready", 32'(in_ready),  32'd0);
        chk("ill0_hold",  32'(proc_hold), 32'd1);
        tick();
        tx[0] = 16'h1111; tx[1] = 16'h2222;
        start_load(2);
        @(negedge clk);
        chk("ill0_err_clear", 32'(err), 32'd0);
        tick();
        send(2, 1'b0);
        wait_done(20);
        chk("ill0_ram1", 32'(ram[1]), 32'h2222);

        // Illegal count 129, then a legal recovery load
        start_load(129);
        @(negedge clk);
        chk("ill129_err",   32'(err),       32'd1);
        chk("ill129_ready", 32'(in_ready),  32'd0);
        chk("ill129_hold",  32'(proc_hold), 32'd1);
        tick();
        tx[0] = 16'h3333; tx[1] = 16'h4444;
        start_load(2);
        @(negedge clk);
        chk("ill129_err_clear", 32'(err), 32'd0);
        tick();
        send(2, 1'b0);
        wait_done(20);
        chk("ill129_ram0", 32'(ram[0]), 32'h3333);

        // Full depth
        for (int i = 0; i < DP; i++) tx[i] = DW'(i * 257) ^ 16'h5A5A;
        clear_logs();
        start_load(DP);
        send(DP, 1'b0);
        wait_done(20);
        chk("full_writes",    32'(wr_cnt),       32'd128);
        chk("full_addr0_once",32'(wr0_cnt),      32'd1);
        chk("full_last_addr", 32'(last_wr_addr), 32'd127);
        chk("full_last_data", 32'(last_wr_data), 32'h2525);
        chk("full_contig",    32'(contig_bad),   32'd0);

        // Reset after 5 handshakes of a 10-word load
        for (int i = 0; i < 10; i++) tx[i] = 16'hC000 + DW'(i);
        clear_logs();
        start_load(10);
        send(5, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("mid_ready", 32'(in_ready),      32'd0);
        chk("mid_we",    32'(ram_write_en0), 32'd0);
        chk("mid_hold",  32'(proc_hold),     32'd1);
        chk("mid_busy",  32'(busy),          32'd0);
        chk("mid_writes",32'(wr_cnt),        32'd5);
        for (int i = 0; i < 5; i++) chk("mid_ram_keep", 32'(ram[i]), 32'hC000 + 32'(i));
        tick();

        // RUN handoff and re-load from RUN
        tx[0] = 16'h00AA;
        start_load(1);
        send(1, 1'b0);
        wait_done(20);
        pc_in = AW'(10); prog_read_en_in = 1'b1;
        @(negedge clk);
        chk("run_addr",    32'(ram_addr0),    32'd10);
        chk("run_read_en", 32'(ram_read_en0), 32'd1);
        tick();
        start_load(1);
        @(negedge clk);
        chk("reload_hold",    32'(proc_hold),    32'd1);
        chk("reload_start",   32'(proc_start),   32'd0);
        chk("reload_read_en", 32'(ram_read_en0), 32'd0);
        tick();
        tx[0] = 16'h00BB;
        send(1, 1'b0);
        wait_done(20);
        chk("reload_ram0", 32'(ram[0]), 32'h00BB);
        prog_read_en_in = 1'b0;
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
